rr_priority_arbiter: RTL and testbench
======================================

Name: rr_priority_arbiter

Overview:
- Shares one downstream resource among 8 requesters, one grant at a time.
- Two modes, selected at runtime:
  - Fixed priority: the highest set request index wins, the same ordering as the team's 8-bit priority encoder.
  - Round-robin: fair rotation that starts just above the last owner.
- The grant is registered and held while the owner keeps requesting. A hold-time limit forces rotation so no requester can starve the others.
- Sits between the requester bank and the shared datapath and drives its select index.

Parameters:
- N_REQ, 8, number of requesters. Fixed at 8; the index is 3 bits.
- MAX_HOLD, 16, maximum consecutive grant cycles per ownership. Range 1..255.
- HOLD_W, 8, width of the hold counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  8  request vector; bit i is requester i.
- rr_mode  in  1  1 = round-robin, 0 = fixed priority (highest index wins).
- grant  out  8  one-hot grant vector, registered.
- grant_id  out  3  index of the current owner, registered.
- grant_valid  out  1  high while grant is non-zero.
- timeout_pulse  out  1  one-cycle pulse when an ownership is ended by MAX_HOLD.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - grant = 0, grant_id = 0, grant_valid = 0, timeout_pulse = 0.
  - last_id pointer = 7, so round-robin starts its search at index 0.
  - Hold counter = 0, state = IDLE.
- State machine: IDLE, OWN.
- IDLE:
  - If req != 0, arbitrate and go to OWN. The grant appears on the next rising edge, a 1-cycle latency from req.
  - If req == 0, stay in IDLE with all outputs 0.
- OWN:
  - The owner keeps the grant while req[grant_id] = 1 and hold_cnt < MAX_HOLD-1. hold_cnt increments each cycle.
  - Release: the owner drops req[grant_id] while owning.
    - Re-arbitrate in the same cycle among the current req.
    - If any request is present, the new grant is registered at the next edge, with no idle gap. Otherwise go to IDLE.
  - Timeout: hold_cnt reaches MAX_HOLD-1 with the owner still requesting.
    - Assert timeout_pulse for the next cycle.
    - Re-arbitrate with the owner's bit masked out.
    - If no other request exists, the owner is re-granted and hold_cnt resets to 0.
  - Every new ownership, including a re-grant, loads hold_cnt = 0 and sets last_id = the new grant_id.
- Fixed priority: winner = highest set index in the eligible vector.
- Round-robin:
  - Search starts at index last_id+1, modulo 8, and wraps through 7 -> 0.
  - The first set bit wins. The pointer wrap is 3-bit natural overflow.
- rr_mode is sampled only at arbitration points. Changing it mid-ownership does not disturb the current grant.
- Request timing:
  - Requests arriving while another requester owns the grant wait; no preemption in either mode.
  - A requester whose req goes low the same cycle it would win is not granted; arbitration uses the current-cycle req.
- Output invariants:
  - grant is always one-hot or zero.
  - grant_valid == |grant.
  - grant_id is valid only when grant_valid = 1 and holds its last value otherwise.
- Reset mid-ownership: all outputs go to 0 immediately, asynchronously. The first arbitration after reset deasserts behaves as from IDLE.

Test Plan:
- Reset then idle: rst_n low with req = 8'hFF -> grant = 0 and grant_valid = 0 throughout. Release reset with req = 0 -> outputs stay 0.
- Fixed priority: rr_mode = 0, req = 8'b0010_0110 -> one cycle later grant = 8'b0010_0000, grant_id = 5. Drop req[5] -> next cycle grant_id = 2, no gap.
- Round-robin rotation: rr_mode = 1, req = 8'hFF held, each owner drops its req for one cycle after being granted -> grant_id sequence 0,1,2,...,7,0 (wrap checked).
- Timeout: MAX_HOLD = 4, req = 8'b0000_1001 held constant in rr_mode -> ownership of 0 for 4 cycles, timeout_pulse for one cycle, then grant_id = 3 for 4 cycles, then 0 again.
- Sole requester timeout: MAX_HOLD = 4, req = 8'b0000_0100 held -> grant_id stays 2 continuously, timeout_pulse every 4 cycles, grant never drops.
- Async reset mid-grant: owner 6 active, pulse rst_n low between edges -> grant = 0 before the next edge. After release with req = 8'h40 -> grant_id = 6 one cycle later and hold_cnt restarts.

Source files
------------

// File: rtl/rr_priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_arbiter
//  Description : Eight-way arbiter for one shared resource. The mode is
//                selectable at run time: fixed priority (the highest index
//                wins) or round-robin (the search starts just above the last
//                owner). The grant is registered and held while the owner
//                keeps requesting. A hold-time limit forces rotation.
//  Ports       : clk           - system clock, rising edge
//                rst_n         - asynchronous active-low reset
//                req[7:0]      - request vector, bit i = requester i
//                rr_mode       - 1 = round-robin, 0 = fixed priority
//                grant[7:0]    - one-hot grant, registered
//                grant_id[2:0] - index of the current owner, registered
//                grant_valid   - high while grant is non-zero
//                timeout_pulse - one-cycle pulse when MAX_HOLD ends an
//                                ownership
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_arbiter #(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             rr_mode,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       grant_id,
    output logic             grant_valid,
    output logic             timeout_pulse
);

    localparam logic [0:0]        c_ST_IDLE   = 1'b0;
    localparam logic [0:0]        c_ST_OWN    = 1'b1;
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] c_HOLD_ONE  = HOLD_W'(1);
    localparam logic [N_REQ-1:0]  c_ONE_HOT0  = N_REQ'(1);

    // Registered state
    logic [0:0]        r_state;
    logic [N_REQ-1:0]  r_grant;
    logic [2:0]        r_grant_id;
    logic [2:0]        r_last_id;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_timeout;

    // Next-state values
    logic [0:0]        w_nxt_state;
    logic [N_REQ-1:0]  w_nxt_grant;
    logic [2:0]        w_nxt_grant_id;
    logic [2:0]        w_nxt_last_id;
    logic [HOLD_W-1:0] w_nxt_hold_cnt;
    logic              w_nxt_timeout;

    // Arbitration
    logic              w_own_req;
    logic              w_timeout;
    logic [N_REQ-1:0]  w_elig;
    logic              w_any;
    logic [2:0]        w_fp_id;
    logic [2:0]        w_rr_id;
    logic [2:0]        w_win_id;

    // ------------------------------------------------------------------
    // Process 1: state and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_last_id  <= 3'd7;     // round-robin search begins at index 0
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_grant    <= w_nxt_grant;
            r_grant_id <= w_nxt_grant_id;
            r_last_id  <= w_nxt_last_id;
            r_hold_cnt <= w_nxt_hold_cnt;
            r_timeout  <= w_nxt_timeout;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration over the current-cycle request vector. On a timeout the
    // owner's bit is masked, so any other requester takes over.
    // ------------------------------------------------------------------
    always_comb begin
        w_own_req = req[r_grant_id];
        w_timeout = (r_state == c_ST_OWN) && w_own_req && (r_hold_cnt == c_HOLD_LAST);
        w_elig    = w_timeout ? (req & ~r_grant) : req;
        w_any     = |w_elig;
    end

    // Fixed priority: a later (higher) set index overrides a lower one.
    always_comb begin
        w_fp_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_elig[i]) begin
                w_fp_id = 3'(i);
            end
        end
    end

    // Round-robin: scan offsets from farthest to nearest so that the
    // first set bit above last_id wins. The offset of 8 wraps to last_id
    // itself, which gives the previous owner the lowest priority.
    always_comb begin : rr_search
        logic [2:0] v_idx;
        w_rr_id = '0;
        v_idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            v_idx = r_last_id + 3'(k);
            if (w_elig[v_idx]) begin
                w_rr_id = v_idx;
            end
        end
    end

    assign w_win_id = rr_mode ? w_rr_id : w_fp_id;

    // ------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_grant    = r_grant;
        w_nxt_grant_id = r_grant_id;
        w_nxt_last_id  = r_last_id;
        w_nxt_hold_cnt = r_hold_cnt;
        w_nxt_timeout  = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                w_nxt_grant = '0;
                if (w_any) begin
                    w_nxt_state    = c_ST_OWN;
                    w_nxt_grant    = c_ONE_HOT0 << w_win_id;
                    w_nxt_grant_id = w_win_id;
                    w_nxt_last_id  = w_win_id;
                    w_nxt_hold_cnt = '0;
                end
            end

            c_ST_OWN: begin
                if (w_timeout) begin
                    // A sole requester is re-granted, which starts a fresh
                    // ownership.
                    w_nxt_timeout  = 1'b1;
                    w_nxt_hold_cnt = '0;
                    if (w_any) begin
                        w_nxt_grant    = c_ONE_HOT0 << w_win_id;
                        w_nxt_grant_id = w_win_id;
                        w_nxt_last_id  = w_win_id;
                    end else begin
                        w_nxt_last_id  = r_grant_id;
                    end
                end else if (!w_own_req) begin
                    if (w_any) begin
                        w_nxt_grant    = c_ONE_HOT0 << w_win_id;
                        w_nxt_grant_id = w_win_id;
                        w_nxt_last_id  = w_win_id;
                        w_nxt_hold_cnt = '0;
                    end else begin
                        // grant_id keeps its last value while idle
                        w_nxt_state    = c_ST_IDLE;
                        w_nxt_grant    = '0;
                        w_nxt_hold_cnt = '0;
                    end
                end else begin
                    w_nxt_hold_cnt = r_hold_cnt + c_HOLD_ONE;
                end
            end

            default: begin
                w_nxt_state    = c_ST_IDLE;
                w_nxt_grant    = '0;
                w_nxt_hold_cnt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin
        grant         = r_grant;
        grant_id      = r_grant_id;
        grant_valid   = |r_grant;
        timeout_pulse = r_timeout;
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_priority_arbiter
//  Description : Scoreboard bench for rr_priority_arbiter with MAX_HOLD = 4.
//                The driver applies one request vector per cycle and queues
//                the hand-computed outputs expected after the next rising
//                edge. A monitor compares them one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_priority_arbiter;

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] id;
        logic       valid;
        logic       to;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       rr_mode;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout_pulse;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    rr_priority_arbiter #(
        .N_REQ    (8),
        .MAX_HOLD (4),
        .HOLD_W   (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .rr_mode       (rr_mode),
        .grant         (grant),
        .grant_id      (grant_id),
        .grant_valid   (grant_valid),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Build an expectation for the next edge and queue it
    task automatic push_exp(input logic [2:0] id, input logic valid, input logic to);
        exp_t       e;
        logic [7:0] one;
        one     = 8'd1;
        e.grant = valid ? (one << id) : 8'd0;
        e.id    = id;
        e.valid = valid;
        e.to    = to;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic [7:0] r, input logic m,
                        input logic [2:0] id, input logic valid, input logic to);
        @(negedge clk);
        req     = r;
        rr_mode = m;
        push_exp(id, valid, to);
    endtask

    // Immediate check used while reset is asserted
    task automatic check_reset(input string name);
        checks++;
        if (grant !== 8'd0 || grant_valid !== 1'b0 || grant_id !== 3'd0 || timeout_pulse !== 1'b0) begin
            failures++;
            $display("FAIL %s: got grant=%h id=%0d valid=%b to=%b, required all zero",
                     name, grant, grant_id, grant_valid, timeout_pulse);
        end
    endtask

    // Monitor: compare queued expectation after each edge, plus invariants
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (grant !== e.grant || grant_id !== e.id || grant_valid !== e.valid || timeout_pulse !== e.to) begin
                failures++;
                $display("FAIL sb t=%0t: got grant=%h id=%0d valid=%b to=%b, required grant=%h id=%0d valid=%b to=%b",
                         $time, grant, grant_id, grant_valid, timeout_pulse, e.grant, e.id, e.valid, e.to);
            end
        end
        if (rst_n === 1'b1) begin
            checks++;
            if ((grant & (grant - 8'd1)) !== 8'd0 || grant_valid !== (|grant)) begin
                failures++;
                $display("FAIL invariant t=%0t: grant=%h valid=%b, required one-hot/zero and valid==|grant",
                         $time, grant, grant_valid);
            end
        end
    end

    initial begin
        rst_n   = 1'b1;
        req     = 8'hFF;
        rr_mode = 1'b0;
        #1 rst_n = 1'b0;

        // Reset with every request high: outputs stay zero
        #2 check_reset("reset_start");
        repeat (3) @(negedge clk);
        check_reset("reset_held");
        req   = 8'h00;
        rst_n = 1'b1;
        step(8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
        step(8'h00, 1'b0, 3'd0, 1'b0, 1'b0);

        // Fixed priority, release with no gap, no preemption, fixed timeout
        step(8'b0010_0110, 1'b0, 3'd5, 1'b1, 1'b0);
        step(8'b0000_0110, 1'b0, 3'd2, 1'b1, 1'b0);
        step(8'b0000_0000, 1'b0, 3'd2, 1'b0, 1'b0);
        step(8'b0000_0010, 1'b0, 3'd1, 1'b1, 1'b0);
        step(8'b1000_0010, 1'b0, 3'd1, 1'b1, 1'b0);
        step(8'b1000_0010, 1'b0, 3'd1, 1'b1, 1'b0);
        step(8'b1000_0010, 1'b0, 3'd1, 1'b1, 1'b0);
        step(8'b1000_0010, 1'b0, 3'd7, 1'b1, 1'b1);
        step(8'b0000_0000, 1'b0, 3'd7, 1'b0, 1'b0);

        // Round-robin rotation with wrap: last owner 7, so start at 0
        step(8'hFF, 1'b1, 3'd0, 1'b1, 1'b0);
        step(8'hFE, 1'b1, 3'd1, 1'b1, 1'b0);
        step(8'hFD, 1'b1, 3'd2, 1'b1, 1'b0);
        step(8'hFB, 1'b1, 3'd3, 1'b1, 1'b0);
        step(8'hF7, 1'b1, 3'd4, 1'b1, 1'b0);
        step(8'hEF, 1'b1, 3'd5, 1'b1, 1'b0);
        step(8'hDF, 1'b1, 3'd6, 1'b1, 1'b0);
        step(8'hBF, 1'b1, 3'd7, 1'b1, 1'b0);
        step(8'h7F, 1'b1, 3'd0, 1'b1, 1'b0);
        step(8'h00, 1'b1, 3'd0, 1'b0, 1'b0);

        // Reset again so the round-robin pointer returns to 7
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset("reset_between");
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin timeout between requesters 0 and 3
        step(8'b0000_1001, 1'b1, 3'd0, 1'b1, 1'b0);
        repeat (3) step(8'b0000_1001, 1'b1, 3'd0, 1'b1, 1'b0);
        step(8'b0000_1001, 1'b1, 3'd3, 1'b1, 1'b1);
        repeat (3) step(8'b0000_1001, 1'b1, 3'd3, 1'b1, 1'b0);
        step(8'b0000_1001, 1'b1, 3'd0, 1'b1, 1'b1);
        step(8'b0000_1001, 1'b1, 3'd0, 1'b1, 1'b0);
        step(8'b0000_0000, 1'b1, 3'd0, 1'b0, 1'b0);

        // Sole requester: re-granted on each timeout, grant never drops
        step(8'b0000_0100, 1'b1, 3'd2, 1'b1, 1'b0);
        repeat (3) step(8'b0000_0100, 1'b1, 3'd2, 1'b1, 1'b0);
        step(8'b0000_0100, 1'b1, 3'd2, 1'b1, 1'b1);
        repeat (3) step(8'b0000_0100, 1'b1, 3'd2, 1'b1, 1'b0);
        step(8'b0000_0100, 1'b1, 3'd2, 1'b1, 1'b1);
        step(8'b0000_0000, 1'b1, 3'd2, 1'b0, 1'b0);

        // Asynchronous reset in the middle of owner 6's hold
        step(8'h40, 1'b0, 3'd6, 1'b1, 1'b0);
        step(8'h40, 1'b0, 3'd6, 1'b1, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("async_reset_mid_grant");
        #1 rst_n = 1'b1;
        push_exp(3'd6, 1'b1, 1'b0);     // fresh grant from IDLE, hold restarts
        repeat (3) step(8'h40, 1'b0, 3'd6, 1'b1, 1'b0);
        step(8'h40, 1'b0, 3'd6, 1'b1, 1'b1);
        step(8'h00, 1'b0, 3'd6, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending entries, required 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
